updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised up/down modulo counter that generalises the free-running binary counter.
//   - Configurable width and modulus.
//   - Synchronous load and clear.
//   - Wrap, saturate and one-shot modes.
//   - Terminal-count pulse and sticky overflow flag.
//   Used as the event/timing counter feeding control FSMs elsewhere in the design.
// PARAMETERS
//   WIDTH      6    count width in bits (2..32)
//   MAX_COUNT  63   terminal value for up-counting; must be <= 2**WIDTH-1
//   PRESCALE   4    enable qualifications per step (used only with COUNTER_PRESCALE_EN; >=1)
// PORTS
//   clk       in   1      single clock, all logic on posedge
//   rst       in   1      synchronous, active-high reset
//   en        in   1      count enable (one step per qualified cycle)
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  load value; clamped to MAX_COUNT if larger
//   clr       in   1      synchronous clear (count=0, flags cleared, FSM to IDLE)
//   mode      in   2      00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   count     out  WIDTH  registered count
//   tc        out  1      one-cycle terminal-count pulse, registered with count
//   ovf       out  1      sticky overflow/underflow flag
//   busy      out  1      1 while FSM is in RUN
// BEHAVIOUR
//   - Reset: count=0, tc=0, ovf=0, busy=0, FSM=IDLE; prescaler=0.
//   - Priority per cycle: rst > clr > load > en step. All outputs update on the clock edge after the inputs.
//   - Terminal values: up -> MAX_COUNT, down -> 0. Arithmetic is modulo MAX_COUNT+1, never 2**WIDTH.
//   - Wrap: up from MAX_COUNT -> 0; down from 0 -> MAX_COUNT. The wrapping step sets tc=1 and ovf=1.
//   - Saturate: a step into the terminal value sets tc=1. A step attempted at the terminal holds count and sets ovf=1, with tc=0.
//   - One-shot: a step into the terminal sets tc=1 and moves the FSM to DONE. In DONE, en is ignored and count holds.
//   - FSM states IDLE, RUN, DONE:
//     - IDLE -> RUN on en or load (same-cycle step/load applies).
//     - RUN -> DONE only in mode 10 on a terminal event.
//     - DONE -> RUN on load, or on en if mode != 10.
//     - Any state -> IDLE on clr/rst.
//   - load: count <= min(load_val, MAX_COUNT), tc=0, ovf unchanged, FSM -> RUN.
//   - load coincident with en: load wins and no step occurs in that cycle.
//   - clr coincident with load/en: clr wins.
//   - Direction and mode are sampled every cycle; changing them mid-count takes effect on the next step.
//   - tc is never asserted for two consecutive cycles unless two consecutive terminal events occur (wrap mode, MAX_COUNT=0).
//   - busy == (FSM==RUN).
// CONFIGURATION
//   - COUNTER_PRESCALE_EN defined: a step occurs only on every PRESCALE-th cycle with en=1.
//     - Internal prescale counter holds while en=0.
//     - Prescale counter is zeroed by rst, clr and load.
//   - COUNTER_PRESCALE_EN undefined: every en=1 cycle is a step. PRESCALE is ignored and no prescale register exists.
// TESTING (WIDTH=6, MAX_COUNT=39, prescale macro off unless noted)
//   1. Reset: rst=1 for 2 cycles with en=1 -> count=0, tc=0, ovf=0, busy=0.
//   2. Wrap up: mode=00, up_dn=1, en=1 for 41 cycles -> count 0..39 then 0; tc=1 only on the cycle count=0 after 39; ovf=1 from then on.
//   3. Saturate down: load 2, mode=01, up_dn=0, en=1 for 4 cycles -> count 1,0,0,0; tc=1 at the first 0; ovf=1 at the second 0.
//   4. One-shot: load 37, mode=10, up, en=1 for 5 cycles -> count 38,39,39,39,39; tc pulses at 39; busy=0 from then on.
//      Then load 5 -> busy=1, count=5.
//   5. Priority: en=1, load=1 (load_val=50), clr=0 -> count=39 (clamped) with no step.
//      Next cycle clr=1, load=1 -> count=0, ovf=0, busy=0.
//   6. Prescale macro on, PRESCALE=4: en=1 for 12 cycles with one en=0 gap after cycle 6 -> count 0->3, with steps on qualified cycles 4, 8 and 12 only.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap, saturate and one-shot modes, terminal-count pulse and sticky overflow.
// Optional prescaler: define COUNTER_PRESCALE_EN to step only on every PRESCALE-th enabled cycle.
module updown_mod_counter #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 63,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  state_t           state;
  logic             step_q;
  logic             step_ok;
  logic             mode_sat;
  logic             mode_one;
  logic             at_term;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pcnt;

  // Prescaler only advances on enabled cycles and restarts on any load/clear.
  always_ff @(posedge clk) begin
    if (rst || clr || load) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == PW'(PRESCALE - 1)) ? '0 : pcnt + 1'b1;
    end
  end

  assign step_q = en && (pcnt == PW'(PRESCALE - 1));
`else
  assign step_q = en;
`endif

  always_comb begin
    mode_sat     = (mode == 2'b01);
    mode_one     = (mode == 2'b10);
    term_val     = up_dn ? MAXV : '0;
    at_term      = (count == term_val);
    load_clamped = (load_val > MAXV) ? MAXV : load_val;
    nxt          = count;
    if (up_dn) begin
      nxt = at_term ? '0 : count + 1'b1;
    end else begin
      nxt = at_term ? MAXV : count - 1'b1;
    end
    // A finished one-shot ignores enable until reloaded or switched out of one-shot mode.
    step_ok = step_q && !((state == DONE) && mode_one);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      state <= IDLE;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      state <= RUN;
    end else if (step_ok) begin
      state <= RUN;
      if (at_term) begin
        if (mode_sat) begin
          tc  <= 1'b0;
          ovf <= 1'b1;
        end else if (mode_one) begin
          tc    <= 1'b0;
          state <= DONE;
        end else begin
          count <= nxt;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end
      end else begin
        count <= nxt;
        tc    <= (mode_sat || mode_one) && (nxt == term_val);
        if (mode_one && (nxt == term_val)) begin
          state <= DONE;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=6, MAX_COUNT=39, PRESCALE=4).
module tb_updown_mod_counter;

  localparam int WIDTH = 6;
  localparam int MAXC  = 39;

  logic             clk = 1'b0;
  logic             rst, en, up_dn, load, clr;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tc, ovf, busy;

  int total = 0;
  int bad   = 0;

  updown_mod_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr(clr), .mode(mode),
    .count(count), .tc(tc), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_clr();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; mode = 2'b00; load = 1'b0; clr = 1'b0; load_val = '0;
    tick(); tick();
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    logic [WIDTH-1:0] exp_cnt;
    do_clr();
    mode = 2'b00; up_dn = 1'b1; en = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      tick();
      exp_cnt = WIDTH'(k % (MAXC + 1));
      total++; if (count !== exp_cnt) begin bad++; $display("FAIL wrap_count k=%0d got=%0d want=%0d", k, count, exp_cnt); end
      total++; if (tc !== (k == 40)) begin bad++; $display("FAIL wrap_tc k=%0d got=%b want=%b", k, tc, (k == 40)); end
      total++; if (ovf !== (k >= 40)) begin bad++; $display("FAIL wrap_ovf k=%0d got=%b want=%b", k, ovf, (k >= 40)); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy k=%0d got=%b want=1", k, busy); end
    end
    idle_inputs();
  endtask

  task automatic test_sat_down();
    logic [WIDTH-1:0] exp_cnt [4] = '{6'd1, 6'd0, 6'd0, 6'd0};
    logic             exp_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic             exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clr();
    load = 1'b1; load_val = 6'd2; mode = 2'b01; up_dn = 1'b0;
    tick();
    load = 1'b0;
    total++; if (count !== 6'd2) begin bad++; $display("FAIL sat_load got=%0d want=2", count); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL sat_count i=%0d got=%0d want=%0d", i, count, exp_cnt[i]); end
      total++; if (tc !== exp_tc[i]) begin bad++; $display("FAIL sat_tc i=%0d got=%b want=%b", i, tc, exp_tc[i]); end
      total++; if (ovf !== exp_ovf[i]) begin bad++; $display("FAIL sat_ovf i=%0d got=%b want=%b", i, ovf, exp_ovf[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] exp_cnt  [5] = '{6'd38, 6'd39, 6'd39, 6'd39, 6'd39};
    logic             exp_tc   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic             exp_busy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_clr();
    load = 1'b1; load_val = 6'd37; mode = 2'b10; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL oneshot_count i=%0d got=%0d want=%0d", i, count, exp_cnt[i]); end
      total++; if (tc !== exp_tc[i]) begin bad++; $display("FAIL oneshot_tc i=%0d got=%b want=%b", i, tc, exp_tc[i]); end
      total++; if (busy !== exp_busy[i]) begin bad++; $display("FAIL oneshot_busy i=%0d got=%b want=%b", i, busy, exp_busy[i]); end
    end
    en = 1'b0; load = 1'b1; load_val = 6'd5;
    tick();
    load = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL oneshot_reload_busy got=%b want=1", busy); end
    total++; if (count !== 6'd5) begin bad++; $display("FAIL oneshot_reload_count got=%0d want=5", count); end
    idle_inputs();
  endtask

  task automatic test_priority();
    do_clr();
    mode = 2'b00; up_dn = 1'b1;
    en = 1'b1; load = 1'b1; load_val = 6'd50;
    tick();
    total++; if (count !== 6'd39) begin bad++; $display("FAIL prio_load_clamp got=%0d want=39", count); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL prio_load_tc got=%b want=0", tc); end
    load = 1'b0;
    tick();
    total++; if (count !== 6'd0) begin bad++; $display("FAIL prio_wrap_count got=%0d want=0", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL prio_wrap_ovf got=%b want=1", ovf); end
    en = 1'b0; load = 1'b1; load_val = 6'd10;
    tick();
    total++; if (count !== 6'd10) begin bad++; $display("FAIL prio_load10 got=%0d want=10", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL prio_load_keeps_ovf got=%b want=1", ovf); end
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 6'd20;
    tick();
    total++; if (count !== 6'd0) begin bad++; $display("FAIL prio_clr_count got=%0d want=0", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL prio_clr_ovf got=%b want=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_clr_busy got=%b want=0", busy); end
    idle_inputs();
  endtask

  task automatic test_down_wrap_mode11();
    do_clr();
    mode = 2'b11; up_dn = 1'b0; en = 1'b1;
    tick();
    total++; if (count !== 6'd39) begin bad++; $display("FAIL dnwrap_count got=%0d want=39", count); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL dnwrap_tc got=%b want=1", tc); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL dnwrap_ovf got=%b want=1", ovf); end
    tick();
    total++; if (count !== 6'd38) begin bad++; $display("FAIL dnwrap_next got=%0d want=38", count); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL dnwrap_next_tc got=%b want=0", tc); end
    idle_inputs();
  endtask

  // Twelve enabled cycles with one disabled gap after the sixth.
  task automatic test_prescale();
`ifdef COUNTER_PRESCALE_EN
    int ps = 4;
`else
    int ps = 1;
`endif
    int q = 0;
    logic [WIDTH-1:0] exp_cnt;
    do_clr();
    mode = 2'b00; up_dn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 6) begin
        en = 1'b0;
      end else begin
        en = 1'b1;
        q++;
      end
      tick();
      exp_cnt = WIDTH'(q / ps);
      total++; if (count !== exp_cnt) begin bad++; $display("FAIL prescale_count i=%0d got=%0d want=%0d", i, count, exp_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    up_dn = 1'b1; mode = 2'b00; load_val = '0;
    test_reset();
`ifndef COUNTER_PRESCALE_EN
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_priority();
    test_down_wrap_mode11();
`endif
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
